gcd_frac_reduce: RTL and testbench

//  Downstream stage of the GCD engine: reduces a fraction num/den to lowest terms.

---
 rtl/gcd_frac_reduce.sv | 129 ++++++++++++
 tb/tb_gcd_frac_reduce.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_frac_reduce.sv
// Reduces num/den to lowest terms by dividing both by a supplied gcd.
// Two restoring dividers run side by side, one quotient bit per clock.
module gcd_frac_reduce #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] den_in,
  input  logic [WIDTH-1:0] gcd_in,
  input  logic             gcd_done,
  output logic             busy,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_zero,
  output logic             err_rem,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] q_num, q_den;
  logic [WIDTH:0]   rem_n, rem_d;
  logic [WIDTH:0]   rem_n_nxt, rem_d_nxt;
  logic [WIDTH-1:0] q_num_nxt, q_den_nxt;
  logic             accept;

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. Returns {remainder, quotient}.
  function automatic logic [2*WIDTH:0] div_step(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh;
    sh = {r, q[WIDTH-1]};
    if (sh >= {1'b0, d})
      div_step = {sh - {1'b0, d}, q[WIDTH-2:0], 1'b1};
    else
      div_step = {sh, q[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    {rem_n_nxt, q_num_nxt} = div_step(rem_n[WIDTH-1:0], q_num, g);
    {rem_d_nxt, q_den_nxt} = div_step(rem_d[WIDTH-1:0], q_den, g);
  end

  // A strobe is taken in IDLE, or in HOLD on the same edge as the handshake.
  assign accept = gcd_done && ((state == IDLE) || ((state == HOLD) && out_ready));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      g         <= '0;
      q_num     <= '0;
      q_den     <= '0;
      rem_n     <= '0;
      rem_d     <= '0;
      out_num   <= '0;
      out_den   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err_zero  <= 1'b0;
      err_rem   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        DIV: begin
          if (gcd_done)
            overrun <= 1'b1;
          if (cnt != '0) begin
            rem_n <= rem_n_nxt;
            rem_d <= rem_d_nxt;
            q_num <= q_num_nxt;
            q_den <= q_den_nxt;
            cnt   <= cnt - CW'(1);
          end else begin
            out_num   <= q_num;
            out_den   <= q_den;
            err_rem   <= (rem_n != '0) || (rem_d != '0);
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (gcd_done) begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase

      // Later assignments here override the HOLD handshake for back-to-back jobs.
      if (accept) begin
        busy    <= 1'b1;
        err_rem <= 1'b0;
        if (gcd_in == '0) begin
          out_num   <= num_in;
          out_den   <= den_in;
          err_zero  <= 1'b1;
          out_valid <= 1'b1;
          state     <= HOLD;
        end else begin
          q_num     <= num_in;
          q_den     <= den_in;
          g         <= gcd_in;
          rem_n     <= '0;
          rem_d     <= '0;
          cnt       <= CW'(WIDTH);
          err_zero  <= 1'b0;
          out_valid <= 1'b0;
          state     <= DIV;
        end
      end
    end
  end

endmodule

// File: tb/tb_gcd_frac_reduce.sv
// Directed bench for gcd_frac_reduce (WIDTH=8) with hand-computed expectations.
module tb_gcd_frac_reduce;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset_n;
  logic [WIDTH-1:0] num_in, den_in, gcd_in;
  logic             gcd_done;
  logic             busy;
  logic [WIDTH-1:0] out_num, out_den;
  logic             out_valid;
  logic             out_ready;
  logic             err_zero, err_rem, overrun;

  int total = 0;
  int bad   = 0;
  int edges;

  gcd_frac_reduce #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .num_in    (num_in),
    .den_in    (den_in),
    .gcd_in    (gcd_in),
    .gcd_done  (gcd_done),
    .busy      (busy),
    .out_num   (out_num),
    .out_den   (out_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_zero  (err_zero),
    .err_rem   (err_rem),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Presents one strobe; returns at the falling edge after the sampling edge.
  task automatic strobe(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] gg);
    @(negedge clock);
    num_in   = n;
    den_in   = d;
    gcd_in   = gg;
    gcd_done = 1'b1;
    @(negedge clock);
    gcd_done = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen, bounded to 50.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    num_in    = '0;
    den_in    = '0;
    gcd_in    = '0;
    gcd_done  = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_num", out_num, 0);
    check("rst_den", out_den, 0);
    check("rst_errs", {err_zero, err_rem, overrun}, 0);
    reset_n = 1'b1;

    // 12/18 gcd 6 -> 2/3 after WIDTH+1 edges, then held under backpressure
    strobe(8'd12, 8'd18, 8'd6);
    check("a_busy", busy, 1);
    wait_valid(edges);
    check("a_latency", edges, 9);
    check("a_num", out_num, 2);
    check("a_den", out_den, 3);
    check("a_errs", {err_zero, err_rem}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("a_hold_valid", out_valid, 1);
      check("a_hold_pair", {out_num, out_den}, {8'd2, 8'd3});
    end

    // handshake edge also carries the next strobe: 8/12 gcd 4
    num_in    = 8'd8;
    den_in    = 8'd12;
    gcd_in    = 8'd4;
    gcd_done  = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    gcd_done  = 1'b0;
    out_ready = 1'b0;
    check("b2b_overrun", overrun, 0);
    check("b2b_valid_drop", out_valid, 0);
    check("b2b_busy", busy, 1);
    wait_valid(edges);
    check("b2b_latency", edges, 9);
    check("b2b_pair", {out_num, out_den}, {8'd2, 8'd3});
    handshake("b2b");

    // zero gcd passes operands through at the sampling edge
    strobe(8'd0, 8'd5, 8'd0);
    check("z_valid", out_valid, 1);
    check("z_pair", {out_num, out_den}, {8'd0, 8'd5});
    check("z_err_zero", err_zero, 1);
    check("z_err_rem", err_rem, 0);
    handshake("z");

    strobe(8'd255, 8'd255, 8'd255);
    wait_valid(edges);
    check("ff_latency", edges, 9);
    check("ff_pair", {out_num, out_den}, {8'd1, 8'd1});
    check("ff_errs", {err_zero, err_rem}, 0);
    handshake("ff");

    strobe(8'd255, 8'd1, 8'd1);
    wait_valid(edges);
    check("max_pair", {out_num, out_den}, {8'd255, 8'd1});
    check("max_errs", {err_zero, err_rem}, 0);
    handshake("max");

    // strobe during DIV is dropped with a single-cycle overrun pulse
    strobe(8'd12, 8'd18, 8'd6);
    repeat (3) @(negedge clock);
    num_in   = 8'd8;
    den_in   = 8'd12;
    gcd_in   = 8'd4;
    gcd_done = 1'b1;
    @(negedge clock);
    gcd_done = 1'b0;
    check("ovr_pulse", overrun, 1);
    @(negedge clock);
    check("ovr_clear", overrun, 0);
    wait_valid(edges);
    check("ovr_valid", out_valid, 1);
    check("ovr_pair", {out_num, out_den}, {8'd2, 8'd3});
    handshake("ovr");

    // 12/7 = 1 r5, 18/7 = 2 r4
    strobe(8'd12, 8'd18, 8'd7);
    wait_valid(edges);
    check("rem_pair", {out_num, out_den}, {8'd1, 8'd2});
    check("rem_err_rem", err_rem, 1);
    check("rem_err_zero", err_zero, 0);
    handshake("rem");

    // asynchronous abort mid-DIV, then a clean job
    strobe(8'd12, 8'd18, 8'd6);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pair", {out_num, out_den}, 0);
    check("arst_flags", {out_valid, err_zero, err_rem, overrun}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("arst_stay_idle", {busy, out_valid}, 0);
    strobe(8'd8, 8'd12, 8'd4);
    wait_valid(edges);
    check("post_latency", edges, 9);
    check("post_pair", {out_num, out_den}, {8'd2, 8'd3});
    handshake("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
